// File: rtl/mux4_way16.sv
// mux4_way16: 4-way WIDTH-bit multiplexer with a registered copy of the
// selected data and selector, plus a one-cycle change-detect pulse.
// Optional feature: define MUX4WAY16_PARITY_EN to add out_par / out_par_q
// (XOR reduction of out, combinational and registered).
module mux4_way16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q,
`ifdef MUX4WAY16_PARITY_EN
  output logic             out_par,
  output logic             out_par_q,
`endif
  output logic             out_chg
);

  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] r_out_q;
  logic [1:0]       r_sel_q;
  logic             r_chg;

  // Select one of four candidates; an unknown selector yields all-X
  // rather than quietly falling through to one of the inputs.
  always_comb begin
    w_out = 'x;
    case (sel)
      2'b00:   w_out = a;
      2'b01:   w_out = b;
      2'b10:   w_out = c;
      2'b11:   w_out = d;
      default: w_out = 'x;
    endcase
  end

  assign out = w_out;

  // Capture the selected data and selector; flag a change against the
  // value held before this edge. Reset wins over any pending capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_q <= '0;
      r_sel_q <= 2'b00;
      r_chg   <= 1'b0;
    end else begin
      r_out_q <= w_out;
      r_sel_q <= sel;
      r_chg   <= (w_out != r_out_q);
    end
  end

  assign out_q   = r_out_q;
  assign sel_q   = r_sel_q;
  assign out_chg = r_chg;

`ifdef MUX4WAY16_PARITY_EN
  logic w_par;
  logic r_par_q;

  assign w_par = ^w_out;

  // Registered parity follows the same capture/reset rules as out_q.
  always_ff @(posedge clk) begin
    if (!rst_n) r_par_q <= 1'b0;
    else        r_par_q <= w_par;
  end

  assign out_par   = w_par;
  assign out_par_q = r_par_q;
`endif

endmodule

// File: tb/tb_mux4_way16.sv
// tb_mux4_way16: directed self-checking bench for mux4_way16.
// Build with MUX4WAY16_PARITY_EN defined to also exercise the parity outputs.
module tb_mux4_way16;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b, c, d;
  logic [1:0]  sel;
  logic [15:0] out, out_q;
  logic [1:0]  sel_q;
  logic        out_chg;
`ifdef MUX4WAY16_PARITY_EN
  logic        out_par, out_par_q;
`endif

  int total = 0;
  int bad   = 0;

  mux4_way16 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .sel     (sel),
    .out     (out),
    .out_q   (out_q),
    .sel_q   (sel_q),
`ifdef MUX4WAY16_PARITY_EN
    .out_par  (out_par),
    .out_par_q(out_par_q),
`endif
    .out_chg (out_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_distinct();
    a = 16'h1234; b = 16'h9876; c = 16'hAAAA; d = 16'h5555;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load_distinct();
    sel = 2'b11;
    tick();
    total++; if (out_q !== 16'h0000) begin bad++; $display("FAIL reset_out_q got=%h exp=0000", out_q); end
    total++; if (sel_q !== 2'b00) begin bad++; $display("FAIL reset_sel_q got=%b exp=00", sel_q); end
    total++; if (out_chg !== 1'b0) begin bad++; $display("FAIL reset_out_chg got=%b exp=0", out_chg); end
    total++; if (out !== 16'h5555) begin bad++; $display("FAIL reset_out_comb got=%h exp=5555", out); end
  endtask

  // all-zero data swept through every selector, still in reset;
  // then the first edge after release sees out==0 so no change pulse
  task automatic test_all_zero();
    a = '0; b = '0; c = '0; d = '0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      total++; if (out !== 16'h0000) begin bad++; $display("FAIL zero_out sel=%0d got=%h exp=0000", i, out); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (out_chg !== 1'b0) begin bad++; $display("FAIL zero_release_chg got=%b exp=0", out_chg); end
    total++; if (out_q !== 16'h0000) begin bad++; $display("FAIL zero_release_out_q got=%h exp=0000", out_q); end
  endtask

  task automatic test_distinct();
    logic [15:0] e [4];
    e[0] = 16'h1234; e[1] = 16'h9876; e[2] = 16'hAAAA; e[3] = 16'h5555;
    load_distinct();
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      total++; if (out !== e[i]) begin bad++; $display("FAIL distinct_out sel=%0d got=%h exp=%h", i, out, e[i]); end
    end
  endtask

  task automatic test_registered();
    load_distinct();
    sel = 2'b01;
    tick();
    total++; if (out_q !== 16'h9876) begin bad++; $display("FAIL reg_out_q1 got=%h exp=9876", out_q); end
    total++; if (sel_q !== 2'b01) begin bad++; $display("FAIL reg_sel_q1 got=%b exp=01", sel_q); end
    total++; if (out_chg !== 1'b1) begin bad++; $display("FAIL reg_chg1 got=%b exp=1", out_chg); end
    sel = 2'b11;
    #1;
    total++; if (out_q !== 16'h9876) begin bad++; $display("FAIL reg_lag got=%h exp=9876", out_q); end
    tick();
    total++; if (out_q !== 16'h5555) begin bad++; $display("FAIL reg_out_q2 got=%h exp=5555", out_q); end
    total++; if (sel_q !== 2'b11) begin bad++; $display("FAIL reg_sel_q2 got=%b exp=11", sel_q); end
    total++; if (out_chg !== 1'b1) begin bad++; $display("FAIL reg_chg2 got=%b exp=1", out_chg); end
  endtask

  task automatic test_hold();
    logic exp_chg [3];
    exp_chg[0] = 1'b1; exp_chg[1] = 1'b0; exp_chg[2] = 1'b0;
    sel = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_chg !== exp_chg[i]) begin bad++; $display("FAIL hold_chg edge=%0d got=%b exp=%b", i, out_chg, exp_chg[i]); end
      total++; if (out_q !== 16'hAAAA) begin bad++; $display("FAIL hold_out_q edge=%0d got=%h exp=aaaa", i, out_q); end
    end
  endtask

  // with sel=10, wiggle a/b/d only
  task automatic test_nonselected();
    a = 16'hFFFF; b = 16'h0001; d = 16'h0F0F;
    #1;
    total++; if (out !== 16'hAAAA) begin bad++; $display("FAIL nonsel_out got=%h exp=aaaa", out); end
    tick();
    total++; if (out_chg !== 1'b0) begin bad++; $display("FAIL nonsel_chg got=%b exp=0", out_chg); end
    total++; if (out_q !== 16'hAAAA) begin bad++; $display("FAIL nonsel_out_q got=%h exp=aaaa", out_q); end
    load_distinct();
  endtask

  task automatic test_reset_mid();
    sel = 2'b11;
    tick();
    rst_n = 1'b0;
    tick();
    total++; if (out_q !== 16'h0000) begin bad++; $display("FAIL rmid_out_q got=%h exp=0000", out_q); end
    total++; if (sel_q !== 2'b00) begin bad++; $display("FAIL rmid_sel_q got=%b exp=00", sel_q); end
    total++; if (out_chg !== 1'b0) begin bad++; $display("FAIL rmid_chg got=%b exp=0", out_chg); end
    total++; if (out !== 16'h5555) begin bad++; $display("FAIL rmid_out got=%h exp=5555", out); end
    rst_n = 1'b1;
    tick();
    total++; if (out_q !== 16'h5555) begin bad++; $display("FAIL rmid_rel_out_q got=%h exp=5555", out_q); end
    total++; if (out_chg !== 1'b1) begin bad++; $display("FAIL rmid_rel_chg got=%b exp=1", out_chg); end
    total++; if (sel_q !== 2'b11) begin bad++; $display("FAIL rmid_rel_sel_q got=%b exp=11", sel_q); end
  endtask

  // sel and newly selected data change in the same step
  task automatic test_simultaneous();
    sel = 2'b00;
    a   = 16'hBEEF;
    #1;
    total++; if (out !== 16'hBEEF) begin bad++; $display("FAIL simul_out got=%h exp=beef", out); end
    tick();
    total++; if (out_q !== 16'hBEEF) begin bad++; $display("FAIL simul_out_q got=%h exp=beef", out_q); end
    total++; if (out_chg !== 1'b1) begin bad++; $display("FAIL simul_chg got=%b exp=1", out_chg); end
    tick();
    total++; if (out_chg !== 1'b0) begin bad++; $display("FAIL simul_chg_drop got=%b exp=0", out_chg); end
    load_distinct();
  endtask

`ifdef MUX4WAY16_PARITY_EN
  task automatic test_parity();
    load_distinct();
    sel = 2'b00;
    #1;
    total++; if (out_par !== 1'b1) begin bad++; $display("FAIL par_1234 got=%b exp=1", out_par); end
    tick();
    total++; if (out_par_q !== 1'b1) begin bad++; $display("FAIL par_q_1234 got=%b exp=1", out_par_q); end
    sel = 2'b10;
    #1;
    total++; if (out_par !== 1'b0) begin bad++; $display("FAIL par_aaaa got=%b exp=0", out_par); end
    tick();
    total++; if (out_par_q !== 1'b0) begin bad++; $display("FAIL par_q_aaaa got=%b exp=0", out_par_q); end
    sel = 2'b00;
    rst_n = 1'b0;
    tick();
    total++; if (out_par_q !== 1'b0) begin bad++; $display("FAIL par_q_reset got=%b exp=0", out_par_q); end
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    sel = 2'b00;
    test_reset();
    test_all_zero();
    test_distinct();
    test_registered();
    test_hold();
    test_nonselected();
    test_reset_mid();
    test_simultaneous();
`ifdef MUX4WAY16_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
